// File: rtl/online_add_seq_pkg.sv
// Shared definitions for the radix-4 online addition sequencer:
// controller state encoding, digit geometry and the signed digit type.
package online_add_seq_pkg;

    // Width of one signed-digit slot and the radix it represents.
    localparam int DIGIT_W = 3;
    localparam int RADIX   = 4;

    // Controller states; the encoding is fixed and visible to other blocks.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FEED  = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_t;

    // One signed radix-4 digit, legal values -3..3.
    typedef logic signed [DIGIT_W-1:0] digit_t;

endpackage

// File: rtl/online_add_seq_adder.sv
// Radix-4 signed-digit online adder, MSD first, online delay 1 plus an
// output register. Each digit sum p = x + y is split into a transfer
// t in {-1,0,1} and an interim w in {-2..2} with p = 4*t + w; the output
// digit for the previous position is w_prev + t, which stays in {-3..3}.
module online_adder_r4
    import online_add_seq_pkg::*;
(
    input  logic   clk,
    input  logic   reset,
    input  logic   en,
    input  digit_t x_d,
    input  digit_t y_d,
    output digit_t z_d
);

    logic signed [3:0] p;
    digit_t            t;
    digit_t            w;
    digit_t            w_prev;
    digit_t            z_next;

    // Split the digit sum into transfer and interim, then form the output digit.
    always_comb begin
        // NOTE: every signal driven here gets a value on every path, so no latch is inferred.
        t      = '0;
        p      = 4'(x_d) + 4'(y_d);
        w      = digit_t'(p);
        if (p >= 4'sd2) begin
            t = 3'sd1;
            w = digit_t'(p - 4'sd4);
        end else if (p <= -4'sd2) begin
            t = -3'sd1;
            w = digit_t'(p + 4'sd4);
        end
        z_next = w_prev + t;
    end

    // Hold the interim digit for the next position and register the output digit.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            w_prev <= '0;
            z_d    <= '0;
        end else if (en) begin
            w_prev <= w;
            z_d    <= z_next;
        end
    end

endmodule

// File: rtl/online_add_seq.sv
// Sequencer around the radix-4 online adder: latches an operand pair,
// streams it digit-serially MSD first, flushes the adder with zero digits
// and collects the N+1 result digits into a parallel word.
module online_add_seq
    import online_add_seq_pkg::*;
#(
    parameter int N     = 8,
    parameter int DELTA = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DIGIT_W*N-1:0]       x_in,
    input  logic [DIGIT_W*N-1:0]       y_in,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DIGIT_W*(N+1)-1:0]   z_out,
    output logic                       busy
);

    localparam int CNT_W = $clog2(N + DELTA + 1);

    state_t                       state;
    state_t                       state_nxt;
    logic [CNT_W-1:0]             cnt;
    logic [DIGIT_W*N-1:0]         x_reg;
    logic [DIGIT_W*N-1:0]         y_reg;
    logic [DIGIT_W*(N+1)-1:0]     z_cap;
    logic                         adder_en;
    logic                         accept;
    logic                         feed_last;
    logic                         flush_last;
    logic                         capture;
    digit_t                       x_dig;
    digit_t                       y_dig;
    digit_t                       z_dig;

    // Datapath conditions derived from state and digit counter.
    // The adder output register holds digit c-1 during FEED cycle c, and
    // digit N-1+j during FLUSH cycle j, so digits 0..N are captured exactly.
    always_comb begin
        accept     = (state == IDLE) && in_valid;
        feed_last  = (cnt == CNT_W'(N - 1));
        flush_last = (cnt == CNT_W'(DELTA - 1));
        capture    = ((state == FEED)  && (cnt != '0)) ||
                     ((state == FLUSH) && (cnt < CNT_W'(2)));
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (in_valid)   state_nxt = FEED;
            FEED:    if (feed_last)  state_nxt = FLUSH;
            FLUSH:   if (flush_last) state_nxt = DONE;
            DONE:    if (out_ready)  state_nxt = IDLE;
            default:                 state_nxt = IDLE;
        endcase
    end

    // Handshake and adder enable outputs; the adder is frozen in IDLE and DONE.
    always_comb begin
        in_ready  = (state == IDLE);
        busy      = (state == FEED) || (state == FLUSH);
        out_valid = (state == DONE);
        adder_en  = busy;
    end

    // Digit counter: counts operand digits in FEED, then flush cycles in FLUSH.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else begin
            unique case (state)
                IDLE:    if (accept) cnt <= '0;
                FEED:    cnt <= feed_last  ? '0 : cnt + CNT_W'(1);
                FLUSH:   cnt <= flush_last ? '0 : cnt + CNT_W'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Operand registers, loaded only on acceptance and untouched until the next one.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x_reg <= '0;
            y_reg <= '0;
        end else if (accept) begin
            x_reg <= x_in;
            y_reg <= y_in;
        end
    end

    // Select the current operand digit pair; zero digits outside FEED drain the adder.
    always_comb begin
        x_dig = '0;
        y_dig = '0;
        if (state == FEED) begin
            for (int i = 0; i < N; i++) begin
                if (cnt == CNT_W'(i)) begin
                    x_dig = x_reg[DIGIT_W*(N-1-i) +: DIGIT_W];
                    y_dig = y_reg[DIGIT_W*(N-1-i) +: DIGIT_W];
                end
            end
        end
    end

    online_adder_r4 u_adder (
        .clk   (clk),
        .reset (reset),
        .en    (adder_en),
        .x_d   (x_dig),
        .y_d   (y_dig),
        .z_d   (z_dig)
    );

    // Capture register: result digits shift in at the bottom, so the MSD ends on top.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            z_cap <= '0;
        end else if (accept) begin
            z_cap <= '0;
        end else if (capture) begin
            z_cap <= {z_cap[DIGIT_W*N-1:0], z_dig};
        end
    end

    assign z_out = z_cap;

endmodule
